// File: rtl/rr_grant_encoder8.sv
// rtl/rr_grant_encoder8.sv - eight-way round-robin arbiter, registered grant index with hold timeout
module rr_grant_encoder8 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic       grant_valid,
  output logic [2:0] grant_idx,
  output logic       timeout
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam bit          HOLD_EN   = (HOLD_MAX != 0);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);

  state_e      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic [2:0]  sel;

  // Walk offsets from the far end so the candidate closest to ptr wins.
  always_comb begin
    sel = ptr_q;
    for (int k = 7; k >= 0; k--) begin
      if (req[ptr_q + 3'(k)]) begin
        sel = ptr_q + 3'(k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          idx_d   = sel;
          cnt_d   = 16'd0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (done || !req[idx_q]) begin
          state_d = ST_IDLE;
          ptr_d   = idx_q + 3'd1;
        end else if (HOLD_EN && (cnt_q == HOLD_LAST)) begin
          state_d   = ST_IDLE;
          ptr_d     = idx_q + 3'd1;
          timeout_d = 1'b1;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 3'd0;
      idx_q     <= 3'd0;
      cnt_q     <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_valid = (state_q == ST_GRANT);
  assign grant_idx   = idx_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_encoder8.sv
// tb/tb_rr_grant_encoder8.sv - randomized and directed bench for rr_grant_encoder8 with HOLD_MAX=4
module tb_rr_grant_encoder8;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: grant state, cycles the current grant has been visible, rotating pointer
  int m_valid = 0, m_idx = 0, m_ptr = 0, m_held = 0, m_to = 0;
  int grant_log[$];

  rr_grant_encoder8 #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    if (!rst_n) begin
      m_valid = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 0;
    end else if (m_valid == 0) begin
      m_to = 0;
      if (req != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (req[(m_ptr + k) % 8]) begin
            m_idx = (m_ptr + k) % 8;
            break;
          end
        end
        m_valid = 1;
        m_held  = 1;
        grant_log.push_back(m_idx);
      end
    end else begin
      if (done || !req[m_idx] || (HOLD != 0 && m_held == HOLD)) begin
        m_to    = (!done && req[m_idx]) ? 1 : 0;
        m_valid = 0;
        m_ptr   = (m_idx + 1) % 8;
      end else begin
        m_to   = 0;
        m_held = m_held + 1;
      end
    end
    @(posedge clk);
    #1;
    check_eq("model_valid", grant_valid, m_valid);
    check_eq("model_idx", grant_idx, m_idx);
    check_eq("model_timeout", timeout, m_to);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    repeat (5) begin
      step();
      check_eq("reset_valid", grant_valid, 0);
      check_eq("reset_idx", grant_idx, 0);
      check_eq("reset_timeout", timeout, 0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int vcnt, tcnt, guard;
    #2;
    do_reset();

    // Single client, done three cycles into the grant
    req = 8'b0000_0100;
    step();
    check_eq("single_valid", grant_valid, 1);
    check_eq("single_idx", grant_idx, 2);
    step();
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    check_eq("single_release", grant_valid, 0);
    req = 8'b0000_1100;
    step();
    check_eq("ptr_after_2", grant_idx, 3);

    // All requesting: rotation 0..7,0 with one dead cycle between grants
    do_reset();
    grant_log.delete();
    req = 8'hFF;
    guard = 0;
    while (grant_log.size() < 9 && guard < 100) begin
      done = (m_valid == 1 && m_held == 2);
      step();
      guard++;
    end
    done = 1'b0;
    check_eq("rotate_count", grant_log.size(), 9);
    for (int i = 0; i < 9 && i < grant_log.size(); i++)
      check_eq("rotate_idx", grant_log[i], i % 8);

    // Wrap search from ptr=6
    do_reset();
    req = 8'h20;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    req = 8'b0010_0001;
    step();
    check_eq("wrap_idx0", grant_idx, 0);
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    check_eq("wrap_idx5", grant_idx, 5);
    check_eq("wrap_valid", grant_valid, 1);

    // Timeout after HOLD cycles
    do_reset();
    req = 8'h08;
    vcnt = 0; tcnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      vcnt += grant_valid;
      tcnt += timeout;
    end
    check_eq("to_valid_cycles", vcnt, 4);
    check_eq("to_pulses", tcnt, 1);
    check_eq("to_coincide_valid", grant_valid, 0);
    check_eq("to_coincide_pulse", timeout, 1);
    req = 8'h18;
    step();
    check_eq("to_ptr4", grant_idx, 4);
    check_eq("to_pulse_end", timeout, 0);

    // done on the last hold cycle wins over timeout
    do_reset();
    req = 8'h08;
    repeat (4) step();
    done = 1'b1;
    step();
    done = 1'b0;
    check_eq("done_vs_to_valid", grant_valid, 0);
    check_eq("done_vs_to_pulse", timeout, 0);

    // Client abandons mid-grant
    do_reset();
    req = 8'h02;
    step();
    step();
    req = 8'h00;
    step();
    check_eq("abandon_valid", grant_valid, 0);
    check_eq("abandon_pulse", timeout, 0);

    // done while idle is ignored
    do_reset();
    done = 1'b1;
    step();
    step();
    check_eq("idle_done_valid", grant_valid, 0);
    done = 1'b0;
    req = 8'h81;
    step();
    check_eq("idle_done_idx", grant_idx, 0);

    // Asynchronous reset mid-grant
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_valid", grant_valid, 0);
    check_eq("async_idx", grant_idx, 0);
    check_eq("async_timeout", timeout, 0);
    do_reset();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 3) req = 8'($urandom) & 8'($urandom);
      done = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_grant_encoder8.md
Name: rr_grant_encoder8

Overview:
- Eight-requester round-robin arbiter with transaction hold and timeout.
- Produces a registered 3-bit grant index plus a valid flag.
- The index feeds the 3-to-8 decoder directly downstream, which expands it into one-hot grant lines.
- Sits between the client request lines and the shared-resource grant fan-out.

Parameters:
- HOLD_MAX, 16: maximum cycles a grant may be held without done before forced release; 0 disables the timeout. Legal range 0..65535.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request lines; bit i = client i; level-sensitive.
- done  input  1  single-cycle pulse from the granted client: transaction complete.
- grant_valid  output  1  grant_idx is an active grant.
- grant_idx  output  3  encoded index of the granted client; drives the downstream decoder input.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (rst_n low, asynchronous):
  - grant_valid=0, grant_idx=3'd0, timeout=0.
  - Priority pointer ptr=3'd0, hold counter=0, state=IDLE.
  - Reset assertion mid-grant aborts the grant immediately, with no timeout pulse.
  - Release of rst_n is synchronous to clk.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first set req bit searching ptr, ptr+1, …, wrapping 7→0.
  - Next edge: grant_idx=selected index, grant_valid=1, counter=0, state=GRANT.
  - Latency from req sampled high to grant_valid high is exactly 1 cycle.
- State GRANT, release conditions evaluated each cycle in this priority order:
  1. done=1: release.
  2. req[grant_idx]=0 (client abandoned): release.
  3. HOLD_MAX!=0 and counter==HOLD_MAX-1: release and pulse timeout=1 on the next cycle.
  4. Otherwise, counter increments (saturating at 16 bits) and grant is held; grant_idx is stable.
- On release:
  - Next edge: grant_valid=0, ptr=grant_idx+1 (3-bit wrap, 7→0), state=IDLE.
  - There is exactly one dead cycle between grants; the earliest next grant_valid is 2 cycles after the release cycle.
- grant_idx retains its last value while grant_valid=0.
  - The decoder output is therefore always one-hot, and consumers must gate it with grant_valid.
- Simultaneous events:
  - done and timeout condition in the same cycle: treated as done; no timeout pulse.
  - done while in IDLE: ignored.
  - Changes to req bits other than grant_idx during GRANT: ignored until the next arbitration.
- Fairness: any client holding req continuously is granted within 8 arbitration rounds.
- timeout is high for exactly one cycle, coincident with grant_valid falling to 0.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset with req=8'h00 for 5 cycles -> grant_valid=0, grant_idx=0, timeout=0 throughout. Assert rst_n low while granted -> grant_valid=0 immediately, before the next clock edge.
- req=8'b0000_0100 applied after reset, done pulsed 3 cycles after grant -> grant_valid=1 with grant_idx=2 one cycle after req. grant_valid=0 on the cycle after done. ptr becomes 3.
- req=8'hFF held, done pulsed 2 cycles after each grant -> grant_idx sequence 0,1,2,…,7,0. Each grant is separated by one grant_valid=0 cycle.
- ptr=6, req=8'b0010_0001 -> grant_idx=0 (search wraps past 7), then grant_idx=5 on the next round.
- HOLD_MAX=4, req[3] held high, no done -> grant_valid is high for 4 cycles, then drops. timeout=1 for exactly one cycle. ptr=4.
- Corner checks:
  - done and the 4th hold cycle coincide -> release with timeout=0.
  - req[grant_idx] dropped mid-grant -> release with no timeout.
  - done asserted in IDLE -> no state change.
